// File: rtl/column_stream_writer.sv
// Buffers ray-cast column records and serialises each frame onto the column decoder's
// 16-bit write bus: one column-reset write, then five data writes per column.
module column_stream_writer #(
  parameter int unsigned NUM_COLS   = 640,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_top,
  input  logic [15:0] in_height,
  input  logic        in_dir,
  input  logic [2:0]  in_tex_type,
  input  logic [5:0]  in_tex_col,
  input  logic [31:0] in_sf,
  output logic        out_chipselect,
  output logic        out_write,
  output logic [3:0]  out_address,
  output logic [15:0] out_writedata,
  output logic        busy,
  output logic        frame_done,
  output logic [9:0]  col_count,
  output logic        err_overrun
);
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_COL = CNT_W'(NUM_COLS);
  localparam logic [CNT_W-1:0]  PENULT   = CNT_W'(NUM_COLS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_WAIT_COL, S_W0, S_W1, S_W2, S_W3, S_W4, S_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] top;
    logic [15:0] height;
    logic        dir;
    logic [2:0]  tex_type;
    logic [5:0]  tex_col;
    logic [31:0] sf;
  } rec_t;

  rec_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_fifo_cnt;
  state_t            r_state;
  logic              r_frame_open;
  logic [CNT_W-1:0]  r_acc_cnt;

  state_t            w_next;
  logic              w_push;
  logic              w_pop;
  logic              w_start;
  logic [PTR_W-1:0]  w_head_idx;
  rec_t              w_head;
  logic              w_write;
  logic [3:0]        w_addr;
  logic [15:0]       w_wdata;

  assign in_ready   = r_frame_open && (r_fifo_cnt != FULL_CNT) && (r_acc_cnt < LAST_COL);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_W4);
  assign w_start    = frame_start && (r_state == S_IDLE);
  // The word registered during W4 belongs to the record behind the one being popped.
  assign w_head_idx = w_pop ? PTR_W'(r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_head     = r_mem[w_head_idx];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (frame_start) w_next = S_SYNC;
      S_SYNC:     w_next = S_WAIT_COL;
      S_WAIT_COL: begin
        if (col_count == LAST_COL)      w_next = S_DONE;
        else if (r_fifo_cnt != '0)      w_next = S_W0;
      end
      S_W0:       w_next = S_W1;
      S_W1:       w_next = S_W2;
      S_W2:       w_next = S_W3;
      S_W3:       w_next = S_W4;
      S_W4: begin
        if (col_count == PENULT)               w_next = S_DONE;
        else if (r_fifo_cnt > FCNT_W'(1))      w_next = S_W0;
        else                                   w_next = S_WAIT_COL;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Bus word for the state being entered, so the bus register lines up with the state.
  always_comb begin
    w_wdata = '0;
    w_write = (w_next inside {S_SYNC, S_W0, S_W1, S_W2, S_W3, S_W4});
    w_addr  = (w_next inside {S_W0, S_W1, S_W2, S_W3, S_W4}) ? 4'd1 : 4'd0;
    case (w_next)
      S_W0:    w_wdata = {6'b0, w_head.dir, w_head.tex_type, w_head.tex_col};
      S_W1:    w_wdata = w_head.height;
      S_W2:    w_wdata = w_head.top;
      S_W3:    w_wdata = w_head.sf[31:16];
      S_W4:    w_wdata = w_head.sf[15:0];
      default: w_wdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{in_top, in_height, in_dir, in_tex_type, in_tex_col, in_sf};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_fifo_cnt     <= '0;
      r_frame_open   <= 1'b0;
      r_acc_cnt      <= '0;
      col_count      <= '0;
      err_overrun    <= 1'b0;
      out_chipselect <= 1'b0;
      out_write      <= 1'b0;
      out_address    <= '0;
      out_writedata  <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      r_state        <= w_next;
      out_chipselect <= w_write;
      out_write      <= w_write;
      out_address    <= w_addr;
      out_writedata  <= w_wdata;
      busy           <= (w_next != S_IDLE) && (w_next != S_DONE);
      frame_done     <= (w_next == S_DONE);

      if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(1));
      if (w_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + PTR_W'(1));
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= FCNT_W'(r_fifo_cnt + FCNT_W'(1));
        2'b01:   r_fifo_cnt <= FCNT_W'(r_fifo_cnt - FCNT_W'(1));
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_start) begin
        r_frame_open <= 1'b1;
        r_acc_cnt    <= '0;
        col_count    <= '0;
        err_overrun  <= 1'b0;
      end else begin
        if (frame_start) err_overrun <= 1'b1;
        // Counters saturate at the frame size; the frame closes on its last acceptance.
        if (w_push && (r_acc_cnt != LAST_COL)) begin
          r_acc_cnt <= CNT_W'(r_acc_cnt + CNT_W'(1));
          if (r_acc_cnt == PENULT) r_frame_open <= 1'b0;
        end
        if (w_pop && (col_count != LAST_COL)) col_count <= CNT_W'(col_count + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_column_stream_writer.sv
// Directed bench for column_stream_writer: a queue-based bus model checked every cycle,
// plus literal expectations for the first words and frame timing.
module tb_column_stream_writer;
  localparam int NC          = 640;
  localparam int FRAME_WORDS = 1 + 5 * NC;

  typedef struct packed {
    logic [15:0] top;
    logic [15:0] height;
    logic        dir;
    logic [2:0]  tex;
    logic [5:0]  col;
    logic [31:0] sf;
  } rec_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_top;
  logic [15:0] in_height;
  logic        in_dir;
  logic [2:0]  in_tex_type;
  logic [5:0]  in_tex_col;
  logic [31:0] in_sf;
  logic        out_chipselect;
  logic        out_write;
  logic [3:0]  out_address;
  logic [15:0] out_writedata;
  logic        busy;
  logic        frame_done;
  logic [9:0]  col_count;
  logic        err_overrun;

  column_stream_writer #(.NUM_COLS(NC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_top(in_top), .in_height(in_height), .in_dir(in_dir),
    .in_tex_type(in_tex_type), .in_tex_col(in_tex_col), .in_sf(in_sf),
    .out_chipselect(out_chipselect), .out_write(out_write),
    .out_address(out_address), .out_writedata(out_writedata),
    .busy(busy), .frame_done(frame_done), .col_count(col_count),
    .err_overrun(err_overrun)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: required event never occurred (t=%0t)", name, $time);
  endtask

  // ---------------- model state, advanced once per cycle at the falling edge
  word_t       q[$];
  word_t       exp_w;
  bit          m_idle = 1'b1, m_busy = 1'b0, m_err = 1'b0, m_done_pend = 1'b0;
  bit          open_now, last_hit, done_now;
  int          m_acc = 0, m_data = 0, m_words = 0, m_ncap = 0, m_done_seen = 0, m_stalls = 0;
  int          cyc = 0, m_sync_cyc = 0, m_first_data_cyc = 0, m_last_cyc = 0;
  logic [15:0] m_cap [8];
  bit          abort = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_write", 32'(out_write), 32'(0));
      chk("rst_cs", 32'(out_chipselect), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_col_count", 32'(col_count), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      q.delete();
      m_idle = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_done_pend = 1'b0;
      m_acc = 0; m_data = 0; m_words = 0;
    end else begin
      open_now = !m_idle && (m_acc < NC);
      last_hit = 1'b0;
      chk("cs_vs_write", 32'(out_chipselect), 32'(out_write));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_done", 32'(frame_done), 32'(m_done_pend));
      chk("col_count", 32'(col_count), 32'(m_data / 5));
      chk("err_overrun", 32'(err_overrun), 32'(m_err));
      if (!open_now) chk("ready_closed", 32'(in_ready), 32'(0));
      if (m_data % 5 != 0) chk("column_contiguous", 32'(out_write), 32'(1));
      if (frame_done) m_done_seen++;
      if (open_now && in_valid && !in_ready) m_stalls++;
      if (out_write) begin
        if (q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          exp_w = q.pop_front();
          chk("address", 32'(out_address), 32'(exp_w.addr));
          chk("writedata", 32'(out_writedata), 32'(exp_w.data));
          if (m_ncap < 8) begin m_cap[m_ncap] = out_writedata; m_ncap++; end
          m_words++;
          if (exp_w.addr == 4'd1) begin
            if (m_data == 0) m_first_data_cyc = cyc;
            m_data++;
          end
          if (m_words == FRAME_WORDS) begin last_hit = 1'b1; m_last_cyc = cyc; end
        end
      end
      done_now    = m_done_pend;
      m_done_pend = last_hit;
      if (last_hit) m_busy = 1'b0;
      // Inputs seen now are consumed by the DUT at the coming rising edge.
      if (frame_start) begin
        if (m_idle) begin
          m_idle = 1'b0; m_busy = 1'b1; m_err = 1'b0;
          m_acc = 0; m_data = 0; m_words = 0; m_ncap = 0; m_done_seen = 0; m_stalls = 0;
          m_sync_cyc = cyc + 1;
          q.push_back('{addr: 4'd0, data: 16'd0});
        end else begin
          m_err = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{addr: 4'd1, data: {6'b0, in_dir, in_tex_type, in_tex_col}});
        q.push_back('{addr: 4'd1, data: in_height});
        q.push_back('{addr: 4'd1, data: in_top});
        q.push_back('{addr: 4'd1, data: in_sf[31:16]});
        q.push_back('{addr: 4'd1, data: in_sf[15:0]});
        m_acc++;
      end
      if (done_now) m_idle = 1'b1;
    end
  end

  // ---------------- stimulus helpers
  task automatic apply(input rec_t r);
    in_top = r.top; in_height = r.height; in_dir = r.dir;
    in_tex_type = r.tex; in_tex_col = r.col; in_sf = r.sf;
  endtask

  task automatic send(input rec_t r);
    bit ok;
    ok = 1'b0;
    apply(r);
    in_valid = 1'b1;
    for (int k = 0; k < 3000 && !abort; k++) begin
      @(negedge clk);
      if (in_ready && !reset) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    else if (!abort) fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("frame_done_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic rec_t rec_b(input int i);
    return '{top: 16'(i * 37 - 200), height: 16'(i + 1), dir: 1'(i & 1),
             tex: 3'(i), col: 6'(i * 5), sf: 32'(i * 65537)};
  endfunction

  function automatic rec_t rec_c(input int i);
    return '{top: 16'(32'hC000 + i), height: 16'(i * 3), dir: 1'(~i & 1),
             tex: 3'(7 - i), col: 6'(63 - i), sf: 32'(32'h00A0_0000 + i)};
  endfunction

  rec_t rec_a = '{top: 16'hFFF0, height: 16'd100, dir: 1'b1, tex: 3'd5, col: 6'd33, sf: 32'h0123_4567};
  rec_t rec_x = '{top: 16'h1234, height: 16'd7, dir: 1'b0, tex: 3'd1, col: 6'd2, sf: 32'h0002_8000};
  rec_t rec_d = '{top: 16'h0020, height: 16'd300, dir: 1'b0, tex: 3'd2, col: 6'd7, sf: 32'hABCD_0001};

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  found, hit;
    reset = 1'b1; frame_start = 1'b0; in_valid = 1'b0;
    apply('0);
    repeat (3) @(posedge clk); #1;
    chk("reset_write", 32'(out_write), 32'(0));
    chk("reset_writedata", 32'(out_writedata), 32'(0));
    chk("reset_err", 32'(err_overrun), 32'(0));
    chk("reset_frame_done", 32'(frame_done), 32'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Frame A: continuous producer, then a 641st record held pending.
    pulse_start();
    for (int i = 0; i < NC; i++) send(rec_a);
    apply(rec_x);
    in_valid = 1'b1;
    wait_done();
    chk("a_ready_641st", 32'(in_ready), 32'(0));
    chk("a_sync_word", 32'(m_cap[0]), 32'h0000);
    chk("a_w0", 32'(m_cap[1]), 32'h0361);
    chk("a_w1", 32'(m_cap[2]), 32'h0064);
    chk("a_w2", 32'(m_cap[3]), 32'hFFF0);
    chk("a_w3", 32'(m_cap[4]), 32'h0123);
    chk("a_w4", 32'(m_cap[5]), 32'h4567);
    chk("a_next_w0", 32'(m_cap[6]), 32'h0361);
    chk("a_sync_to_w0", 32'(m_first_data_cyc - m_sync_cyc), 32'd2);
    chk("a_data_span", 32'(m_last_cyc - m_first_data_cyc), 32'd3199);
    chk("a_words", 32'(m_words), 32'd3201);
    chk("a_done_count", 32'(m_done_seen), 32'd1);
    chk("a_col_count", 32'(col_count), 32'd640);
    chk("a_busy_after", 32'(busy), 32'd0);
    chk("a_queue_drained", 32'(q.size()), 32'd0);

    // Frame B: pending record goes first, then a starved producer; overrun at column 300.
    pulse_start();
    send(rec_x);
    for (int i = 1; i < NC; i++) begin
      repeat (19) @(posedge clk); #1;
      send(rec_b(i));
      if (i == 5) begin
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          if (out_write && !found) begin lat = k; found = 1'b1; end
        end
        chk("b_w0_latency", 32'(lat >= 2 && lat <= 3), 32'd1);
      end
      if (i == 300) begin
        pulse_start();
        @(negedge clk);
        chk("b_err_set", 32'(err_overrun), 32'd1);
      end
    end
    wait_done();
    chk("b_err_hold", 32'(err_overrun), 32'd1);
    chk("b_col_count", 32'(col_count), 32'd640);
    chk("b_done_count", 32'(m_done_seen), 32'd1);
    chk("b_queue_drained", 32'(q.size()), 32'd0);

    // Frame C: records pending before frame_start; reset during W2 of column 10.
    abort = 1'b0;
    fork
      begin
        for (int i = 0; i < 16 && !abort; i++) send(rec_c(i));
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("c_err_cleared", 32'(err_overrun), 32'd0);
        hit = 1'b0;
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk); #1;
          if (out_write && m_data == 53) begin hit = 1'b1; break; end
        end
        if (!hit) fail_now("c_column10_w2");
        chk("c_pre_reset_col", 32'(col_count), 32'd10);
        #1 reset = 1'b1;
        #1;
        chk("c_async_write", 32'(out_write), 32'd0);
        chk("c_async_cs", 32'(out_chipselect), 32'd0);
        chk("c_async_addr", 32'(out_address), 32'd0);
        chk("c_async_data", 32'(out_writedata), 32'd0);
        chk("c_async_busy", 32'(busy), 32'd0);
        chk("c_async_col", 32'(col_count), 32'd0);
        chk("c_async_ready", 32'(in_ready), 32'd0);
        abort = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
      end
    join
    chk("c_ready_dropped_full", 32'(m_stalls > 0), 32'd1);
    abort = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Frame D: fresh frame after reset starts cleanly at column 0.
    pulse_start();
    for (int i = 0; i < NC; i++) send(rec_d);
    wait_done();
    chk("d_sync_word", 32'(m_cap[0]), 32'h0000);
    chk("d_w0", 32'(m_cap[1]), 32'h0087);
    chk("d_w1", 32'(m_cap[2]), 32'h012C);
    chk("d_w2", 32'(m_cap[3]), 32'h0020);
    chk("d_w3", 32'(m_cap[4]), 32'hABCD);
    chk("d_w4", 32'(m_cap[5]), 32'h0001);
    chk("d_data_span", 32'(m_last_cyc - m_first_data_cyc), 32'd3199);
    chk("d_col_count", 32'(col_count), 32'd640);
    chk("d_done_count", 32'(m_done_seen), 32'd1);
    chk("d_queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
